// File: rtl/noise_stats_meter.sv
// Block noise statistics: mean, mean-square and peak |x| over 2^LOG2_N strobed samples.
// Three-stage pipeline (capture, square/abs, accumulate) feeding a small measurement FSM.
module noise_stats_meter #(
  parameter int LOG2_N = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [17:0] sample_in,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        result_valid,
  output logic [17:0] mean_out,
  output logic [17:0] power_out,
  output logic [17:0] peak_out
);

  // Handshake: start is honoured only in IDLE (abort wins if both high); busy stays high
  // until the one-cycle result_valid pulse or an abort; results hold between pulses.
  localparam int SUM_W = 18 + LOG2_N;
  localparam int SQ_W  = 36 + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((2 ** LOG2_N) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     flush_q, flush_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [17:0]       s1_smp_q, s1_smp_d;
  logic                     s2_valid_q, s2_valid_d;
  logic signed [17:0]       s2_smp_q, s2_smp_d;
  logic [35:0]              s2_sq_q, s2_sq_d;
  logic [17:0]              s2_abs_q, s2_abs_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [SQ_W-1:0]          sq_sum_q, sq_sum_d;
  logic [17:0]              peak_q, peak_d;
  logic [17:0]              mean_q, mean_d;
  logic [17:0]              power_q, power_d;
  logic [17:0]              peak_out_q, peak_out_d;
  logic                     rv_q, rv_d;

  logic                     kill;
  logic                     accept;
  logic signed [35:0]       s1_ext;
  logic signed [35:0]       sq_full;

  always_comb begin
    kill    = abort && (state_q != S_IDLE);
    accept  = (state_q == S_ACCUM) && clk_en && !abort;
    s1_ext  = $signed({{18{s1_smp_q[17]}}, s1_smp_q});
    sq_full = s1_ext * s1_ext;

    // Pipeline advances every clock; an abort empties it so nothing stale lands later.
    s1_valid_d = accept;
    s1_smp_d   = accept ? $signed(sample_in) : s1_smp_q;
    s2_valid_d = s1_valid_q && !kill;
    s2_smp_d   = s1_smp_q;
    s2_sq_d    = $unsigned(sq_full);
    s2_abs_d   = s1_smp_q[17] ? $unsigned(-s1_smp_q) : $unsigned(s1_smp_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    sum_d      = sum_q;
    sq_sum_d   = sq_sum_q;
    peak_d     = peak_q;
    mean_d     = mean_q;
    power_d    = power_q;
    peak_out_d = peak_out_q;
    rv_d       = 1'b0;

    if (s2_valid_q && !kill) begin
      sum_d    = sum_q + $signed({{LOG2_N{s2_smp_q[17]}}, s2_smp_q});
      sq_sum_d = sq_sum_q + {{LOG2_N{1'b0}}, s2_sq_q};
      if (s2_abs_q > peak_q) peak_d = s2_abs_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_ACCUM;
          cnt_d    = '0;
          sum_d    = '0;
          sq_sum_d = '0;
          peak_d   = '0;
        end
      end
      S_ACCUM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_FLUSH;
            flush_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        // Two cycles lets the last sample clear stages 2 and 3.
        if (abort) begin
          state_d = S_IDLE;
        end else if (flush_q) begin
          state_d = S_DONE;
        end else begin
          flush_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!abort) begin
          rv_d       = 1'b1;
          mean_d     = sum_q[LOG2_N +: 18];
          power_d    = sq_sum_q[LOG2_N + 17 +: 18];
          peak_out_d = peak_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_smp_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_smp_q   <= '0;
      s2_sq_q    <= '0;
      s2_abs_q   <= '0;
      sum_q      <= '0;
      sq_sum_q   <= '0;
      peak_q     <= '0;
      mean_q     <= '0;
      power_q    <= '0;
      peak_out_q <= '0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      s1_valid_q <= s1_valid_d;
      s1_smp_q   <= s1_smp_d;
      s2_valid_q <= s2_valid_d;
      s2_smp_q   <= s2_smp_d;
      s2_sq_q    <= s2_sq_d;
      s2_abs_q   <= s2_abs_d;
      sum_q      <= sum_d;
      sq_sum_q   <= sq_sum_d;
      peak_q     <= peak_d;
      mean_q     <= mean_d;
      power_q    <= power_d;
      peak_out_q <= peak_out_d;
      rv_q       <= rv_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = rv_q;
  assign mean_out     = mean_q;
  assign power_out    = power_q;
  assign peak_out     = peak_out_q;

endmodule

// File: doc/noise_stats_meter.md
NOISE_STATS_METER -- requirements
Module: noise_stats_meter

Interface
REQ-001 SHALL have parameter LOG2_N, default 10, block length N = 2^LOG2_N samples (legal range 4..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clk_en  input  1  sample strobe; sample_in valid only when high.
REQ-005 SHALL have port sample_in  input  18  signed 1s17 noise sample (e.g. generator output).
REQ-006 SHALL have port start  input  1  single-cycle request to measure one block.
REQ-007 SHALL have port abort  input  1  cancel current measurement.
REQ-008 SHALL have port busy  output  1  high from measurement start until result or abort.
REQ-009 SHALL have port result_valid  output  1  one-cycle pulse when results update.
REQ-010 SHALL have port mean_out  output  18  signed 1s17 block mean.
REQ-011 SHALL have port power_out  output  18  unsigned 1u17 block mean-square.
REQ-012 SHALL have port peak_out  output  18  unsigned 1u17 block max |sample|.

Function
REQ-013 SHALL implement FSM IDLE -> ACCUM -> FLUSH -> DONE -> IDLE.
REQ-014 IDLE: start=1 SHALL clear sum, sum-of-squares, peak and sample counter, and enter ACCUM on the next edge.
REQ-015 Samples SHALL be accepted only in ACCUM on edges where clk_en=1; a sample presented on the start cycle SHALL NOT be counted.
REQ-016 The pipeline SHALL be: stage 1 registers the accepted sample; stage 2 registers its 36-bit signed square (2s34) and 18-bit absolute value; stage 3 accumulates. Each stage carries a valid bit and advances every clock regardless of clk_en.
REQ-017 The sum accumulator SHALL be signed, 18+LOG2_N bits; the square accumulator SHALL be unsigned, 36+LOG2_N bits; neither SHALL overflow.
REQ-018 The edge accepting the Nth sample SHALL move the FSM to FLUSH; FLUSH SHALL last exactly 2 clocks, independent of clk_en.
REQ-019 DONE SHALL last 1 clock, register outputs and assert result_valid.
REQ-020 result_valid SHALL be high exactly on the 3rd rising edge after the edge that accepts the Nth sample.
REQ-021 mean_out SHALL equal sum >>> LOG2_N (arithmetic shift, rounding toward minus infinity).
REQ-022 power_out SHALL equal bits [34:17] of (square sum >> LOG2_N), truncated; the maximum of 1.0 = 18'd131072 SHALL be representable.
REQ-023 peak_out SHALL be the max |sample| over the block; |-1.0| SHALL be 18'd131072.
REQ-024 mean_out, power_out and peak_out SHALL hold their values until the next result_valid.
REQ-025 busy SHALL be high in ACCUM, FLUSH and DONE, and low in IDLE.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort=1 in any non-IDLE state SHALL return to IDLE on the next edge with no result_valid and unchanged outputs; abort SHALL take priority over sample acceptance and state advance.
REQ-028 Simultaneous start and abort in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, busy=0, result_valid=0, mean_out=0, power_out=0, peak_out=0, clear all accumulators, counter and pipeline valid bits.
REQ-030 Reset asserted mid-measurement SHALL discard the measurement; after release no result_valid SHALL occur until a new start.

Verification
REQ-031 LOG2_N=4, start, 16 samples of 18'sd65536 with clk_en=1 -> result_valid 3 clocks after 16th accept; mean_out=65536, power_out=32768, peak_out=65536.
REQ-032 LOG2_N=4, 16 samples of 18'h20000 (-1.0) -> mean_out=-131072, power_out=131072, peak_out=131072.
REQ-033 LOG2_N=4, alternating +65536/-65536 with clk_en high on every 3rd clock -> only strobed samples counted; mean_out=0, power_out=32768, peak_out=65536.
REQ-034 Start, 8 samples, abort -> busy falls next edge, no result_valid, outputs keep prior values; repeated start during busy ignored (counter not cleared).
REQ-035 reset_n pulsed low after 10 samples -> all outputs 0 immediately, busy=0; new start plus 16 samples yields correct results.
REQ-036 Long run, LOG2_N=10, driven from AWGN generator -> |mean_out| < 1311 (0.01), power_out within 10% of 1311 (sigma 0.1), peak_out <= 69468 (0.53).
